mem_wb_stage: RTL

- Memory-access stage plus MEM/WB pipeline register of the 5-stage RV32I core; sits directly downstream of the EX/MEM register.
- Holds the data memory and performs byte/halfword/word stores with byte enables.
- Formats loads with sign/zero extension and registers all writeback-stage signals.
- Provides the final writeback result mux (ResultW) to the register file.

---
 rtl/mem_wb_stage.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - RV32I memory-access stage with data memory and MEM/WB pipeline register
module mem_wb_stage #(
    parameter  int DEPTH_WORDS = 256,
    localparam int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ALU_ResultM,
    input  logic [31:0] writedataM,
    input  logic [31:0] PCPlus4M,
    input  logic [4:0]  rdM,
    input  logic        MemWriteM,
    input  logic        RegWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [2:0]  funct3M,
    output logic [31:0] ALU_ResultW,
    output logic [31:0] ReadDataW,
    output logic [31:0] PCPlus4W,
    output logic [4:0]  rdW,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic        MisalignedW,
    output logic [31:0] ResultW
);

    logic [31:0] r_mem [0:DEPTH_WORDS-1];

    logic [31:0] r_alu_result;
    logic [31:0] r_read_data;
    logic [31:0] r_pc_plus4;
    logic [4:0]  r_rd;
    logic        r_reg_write;
    logic [1:0]  r_result_src;
    logic        r_misaligned;

    logic [ADDR_W-1:0] w_idx;
    logic [1:0]        w_off;
    logic              w_is_byte;
    logic              w_is_half;
    logic              w_is_word;
    logic              w_is_load;
    logic              w_misaligned;
    logic              w_store_en;
    logic [31:0]       w_rd_word;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic              w_sign;
    logic [31:0]       w_load_ext;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic              w_unused_addr;

    // Upper address bits fall off the end so addresses wrap modulo the memory size
    assign w_idx         = ALU_ResultM[ADDR_W+1:2];
    assign w_off         = ALU_ResultM[1:0];
    assign w_unused_addr = ^ALU_ResultM[31:ADDR_W+2];

    assign w_is_byte = (funct3M[1:0] == 2'b00);
    assign w_is_half = (funct3M[1:0] == 2'b01);
    assign w_is_word = funct3M[1];
    assign w_is_load = (ResultSrcM == 2'b01);

    assign w_misaligned = (MemWriteM | w_is_load) &
                          ((w_is_half & w_off[0]) | (w_is_word & (w_off != 2'b00)));

    assign w_store_en = MemWriteM & ~w_misaligned & ~rst;

    // Asynchronous read sees pre-store contents in the same cycle as a store
    assign w_rd_word = r_mem[w_idx];
    assign w_byte    = w_rd_word[{w_off, 3'b000} +: 8];
    assign w_half    = w_off[1] ? w_rd_word[31:16] : w_rd_word[15:0];
    assign w_sign    = ~funct3M[2];

    always_comb begin
        w_load_ext = w_rd_word;
        if (w_is_byte) begin
            w_load_ext = {{24{w_sign & w_byte[7]}}, w_byte};
        end else if (w_is_half) begin
            w_load_ext = {{16{w_sign & w_half[15]}}, w_half};
        end
    end

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = writedataM;
        if (w_is_byte) begin
            w_be    = 4'b0001 << w_off;
            w_wdata = {4{writedataM[7:0]}};
        end else if (w_is_half) begin
            w_be    = w_off[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{writedataM[15:0]}};
        end
    end

    always_ff @(posedge clk) begin
        if (w_store_en) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_result <= 32'd0;
            r_read_data  <= 32'd0;
            r_pc_plus4   <= 32'd0;
            r_rd         <= 5'd0;
            r_reg_write  <= 1'b0;
            r_result_src <= 2'b00;
            r_misaligned <= 1'b0;
        end else begin
            r_alu_result <= ALU_ResultM;
            r_pc_plus4   <= PCPlus4M;
            r_rd         <= rdM;
            r_result_src <= ResultSrcM;
            r_misaligned <= w_misaligned;
            // A faulting load must not retire into the register file
            if (w_is_load & w_misaligned) begin
                r_read_data <= 32'd0;
                r_reg_write <= 1'b0;
            end else begin
                r_read_data <= w_load_ext;
                r_reg_write <= RegWriteM;
            end
        end
    end

    assign ALU_ResultW = r_alu_result;
    assign ReadDataW   = r_read_data;
    assign PCPlus4W    = r_pc_plus4;
    assign rdW         = r_rd;
    assign RegWriteW   = r_reg_write;
    assign ResultSrcW  = r_result_src;
    assign MisalignedW = r_misaligned;

    always_comb begin
        case (r_result_src)
            2'b01:   ResultW = r_read_data;
            2'b10:   ResultW = r_pc_plus4;
            default: ResultW = r_alu_result;
        endcase
    end

endmodule
